// File: rtl/sync_ff_filt.sv
// Multi-channel level synchroniser with per-channel debounce and registered rise/fall strobes.
// Latency: din change to dout/rise/fall is STAGES+FILTER_CNT clk_rx edges; no backpressure.
module sync_ff_filt #(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = 2,
  parameter int               FILTER_CNT = 3,
  parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}}
) (
  input  logic             clk_rx,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  localparam int            CW      = $clog2(FILTER_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CNT - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_ff_filt: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff_filt: STAGES must be >= 2");
  end
  if (FILTER_CNT < 1) begin : g_bad_filter
    $error("sync_ff_filt: FILTER_CNT must be >= 1");
  end

  // Metastability chain: pure flop-to-flop, no logic between stages.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync [WIDTH];

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] w_ds;

  always_comb begin
    w_ds = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ds[i] = r_sync[i][STAGES-1];
    end
  end

  always_ff @(posedge clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_sync[i] <= {STAGES{RST_VAL[i]}};
        r_cnt[i]  <= '0;
      end
      r_dout <= RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_sync[i] <= {r_sync[i][STAGES-2:0], din[i]};
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        // Any return to the current level wipes the run; glitches earn no partial credit.
        if (w_ds[i] == r_dout[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_dout[i] <= w_ds[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= w_ds[i];
          r_fall[i] <= ~w_ds[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign dout     = r_dout;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign any_edge = |(r_rise | r_fall);

endmodule

// File: tb/tb_sync_ff_filt.sv
// Directed bench for sync_ff_filt: default configuration plus two parameter variants sharing one clock/reset.
module tb_sync_ff_filt;

  logic       clk_rx = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] din    = 4'h0;
  logic [3:0] dout, rise, fall;
  logic       any_edge;

  logic din_a = 1'b0, dout_a, rise_a, fall_a, any_a;
  logic din_b = 1'b0, dout_b, rise_b, fall_b, any_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_rx = ~clk_rx;

  sync_ff_filt #(.WIDTH(4), .STAGES(2), .FILTER_CNT(3), .RST_VAL(4'h0)) dut (
    .clk_rx(clk_rx), .rst_n(rst_n), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .any_edge(any_edge)
  );

  sync_ff_filt #(.WIDTH(1), .STAGES(3), .FILTER_CNT(1), .RST_VAL(1'b0)) u_s3 (
    .clk_rx(clk_rx), .rst_n(rst_n), .din(din_a),
    .dout(dout_a), .rise(rise_a), .fall(fall_a), .any_edge(any_a)
  );

  sync_ff_filt #(.WIDTH(1), .STAGES(2), .FILTER_CNT(8), .RST_VAL(1'b0)) u_w1 (
    .clk_rx(clk_rx), .rst_n(rst_n), .din(din_b),
    .dout(dout_b), .rise(rise_b), .fall(fall_b), .any_edge(any_b)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_rx);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held with all inputs high; nothing may leak through or pulse on release.
    din = 4'hF;
    tick(3);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_rise", 32'(rise), 32'h0);
    chk("rst_fall", 32'(fall), 32'h0);
    chk("rst_any", 32'(any_edge), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_dout", 32'(dout), 32'h0);
    chk("rel_rise", 32'(rise), 32'h0);
    tick(4);
    chk("rel_e4_dout", 32'(dout), 32'h0);
    chk("rel_e4_any", 32'(any_edge), 32'h0);
    tick(1);
    chk("rel_e5_dout", 32'(dout), 32'hF);
    chk("rel_e5_rise", 32'(rise), 32'hF);
    chk("rel_e5_fall", 32'(fall), 32'h0);
    chk("rel_e5_any", 32'(any_edge), 32'h1);
    tick(1);
    chk("rel_e6_rise", 32'(rise), 32'h0);
    chk("rel_e6_any", 32'(any_edge), 32'h0);
    chk("rel_e6_dout", 32'(dout), 32'hF);

    // Return all channels low and settle.
    din = 4'h0;
    tick(5);
    chk("clr_fall", 32'(fall), 32'hF);
    tick(1);
    chk("clr_dout", 32'(dout), 32'h0);

    // Latency on channel 0.
    din = 4'b0001;
    tick(4);
    chk("lat_e4_dout", 32'(dout), 32'h0);
    tick(1);
    chk("lat_e5_dout", 32'(dout), 32'h1);
    chk("lat_e5_rise", 32'(rise), 32'h1);
    tick(1);
    chk("lat_e6_rise", 32'(rise), 32'h0);
    chk("lat_e6_dout", 32'(dout), 32'h1);
    din = 4'b0000;
    tick(4);
    chk("lat_f_e4", 32'(fall), 32'h0);
    tick(1);
    chk("lat_f_e5", 32'(fall), 32'h1);
    chk("lat_f_dout", 32'(dout), 32'h0);
    tick(1);
    chk("lat_f_e6", 32'(fall), 32'h0);

    // Two-cycle pulse on channel 1 must be rejected.
    din = 4'b0010;
    tick(2);
    din = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("glitch2_any", 32'(any_edge), 32'h0);
    end
    chk("glitch2_dout", 32'(dout), 32'h0);

    // Three-cycle pulse qualifies, then falls three cycles later.
    din = 4'b0010;
    tick(3);
    din = 4'b0000;
    tick(1);
    chk("p3_e4_dout", 32'(dout), 32'h0);
    tick(1);
    chk("p3_e5_dout", 32'(dout), 32'h2);
    chk("p3_e5_rise", 32'(rise), 32'h2);
    tick(2);
    chk("p3_e7_dout", 32'(dout), 32'h2);
    chk("p3_e7_any", 32'(any_edge), 32'h0);
    tick(1);
    chk("p3_e8_dout", 32'(dout), 32'h0);
    chk("p3_e8_fall", 32'(fall), 32'h2);
    tick(1);
    chk("p3_e9_fall", 32'(fall), 32'h0);

    // Pattern 1,0,1,1,1: only the final run of three qualifies (edge 7).
    din = 4'b0010;
    tick(1);
    din = 4'b0000;
    tick(1);
    din = 4'b0010;
    tick(3);
    din = 4'b0000;
    tick(1);
    chk("p10111_e6_dout", 32'(dout), 32'h0);
    tick(1);
    chk("p10111_e7_dout", 32'(dout), 32'h2);
    chk("p10111_e7_rise", 32'(rise), 32'h2);
    tick(8);
    chk("p10111_settle", 32'(dout), 32'h0);

    // Simultaneous transitions on several channels.
    din = 4'b0101;
    tick(4);
    chk("sim1_e4_any", 32'(any_edge), 32'h0);
    tick(1);
    chk("sim1_rise", 32'(rise), 32'h5);
    chk("sim1_fall", 32'(fall), 32'h0);
    chk("sim1_any", 32'(any_edge), 32'h1);
    tick(1);
    chk("sim1_any_off", 32'(any_edge), 32'h0);
    din = 4'b1010;
    tick(5);
    chk("sim2_rise", 32'(rise), 32'hA);
    chk("sim2_fall", 32'(fall), 32'h5);
    chk("sim2_dout", 32'(dout), 32'hA);
    chk("sim2_any", 32'(any_edge), 32'h1);
    tick(1);
    chk("sim2_any_off", 32'(any_edge), 32'h0);

    // Reset while channel 2 is two cycles into qualifying.
    din = 4'b1110;
    tick(4);
    chk("mid_cnt2", 32'(dut.r_cnt[2]), 32'h2);
    chk("mid_pre_dout", 32'(dout), 32'hA);
    rst_n = 1'b0;
    #1;
    chk("mid_async_dout", 32'(dout), 32'h0);
    chk("mid_async_cnt2", 32'(dut.r_cnt[2]), 32'h0);
    chk("mid_async_rise", 32'(rise), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("mid_e4_dout", 32'(dout), 32'h0);
    chk("mid_e4_any", 32'(any_edge), 32'h0);
    tick(1);
    chk("mid_e5_dout", 32'(dout), 32'hE);
    chk("mid_e5_rise", 32'(rise), 32'hE);

    // Parameter variants: latency STAGES+FILTER_CNT = 4 and 10.
    din_a = 1'b1;
    din_b = 1'b1;
    tick(3);
    chk("s3_e3_dout", 32'(dout_a), 32'h0);
    tick(1);
    chk("s3_e4_dout", 32'(dout_a), 32'h1);
    chk("s3_e4_rise", 32'(rise_a), 32'h1);
    tick(1);
    chk("s3_e5_rise", 32'(rise_a), 32'h0);
    tick(4);
    chk("w1_e9_dout", 32'(dout_b), 32'h0);
    tick(1);
    chk("w1_e10_dout", 32'(dout_b), 32'h1);
    chk("w1_e10_rise", 32'(rise_b), 32'h1);
    chk("w1_e10_any", 32'(any_b), 32'h1);
    tick(1);
    chk("w1_e11_rise", 32'(rise_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
